led_rate_limiter: RTL and testbench



---
 rtl/led_rate_limiter_pkg.sv | 10 +
 rtl/led_rate_limiter_strobe_div.sv | 38 +++
 rtl/led_rate_limiter.sv | 48 ++++
 tb/tb_led_rate_limiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_rate_limiter_pkg.sv
// Shared constants for the LED rate limiter slice.
package led_rate_limiter_pkg;

  // Default divider width: strobe period of 256 clocks.
  localparam int unsigned DefaultDivBits = 8;

  // Smallest divider width that still yields a distinct strobe and a 50% divided clock.
  localparam int unsigned MinDivBits = 2;

endpackage

// File: rtl/led_rate_limiter_strobe_div.sv
// Free-running power-of-two divider producing a one-cycle strobe and a divided clock.
module strobe_div
  import led_rate_limiter_pkg::*;
#(
  parameter int unsigned DIV_BITS = DefaultDivBits
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_stb,
  output logic o_clk
);

  logic [DIV_BITS-1:0] cnt_q;
  logic [DIV_BITS-1:0] cnt_d;
  logic                stb_q;
  logic                stb_d;

  // Next-state: counter wraps naturally, strobe flags the terminal count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    stb_d = (cnt_q == {DIV_BITS{1'b1}});
  end

  // Counter and strobe registers, cleared immediately by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end

  assign o_stb = stb_q;
  assign o_clk = cnt_q[DIV_BITS-1];

endmodule

// File: rtl/led_rate_limiter.sv
// LED rate limiter: the LED output only follows the request on divider strobes.
module led_rate_limiter
  import led_rate_limiter_pkg::*;
#(
  parameter int unsigned DIV_BITS = DefaultDivBits
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_led,
  output logic o_led,
  output logic o_stb,
  output logic o_clk
);

  logic stb;
  logic led_q;
  logic led_d;

  strobe_div #(
    .DIV_BITS(DIV_BITS)
  ) u_strobe_div (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .o_stb(stb),
    .o_clk(o_clk)
  );

  // Take the requested level only in the strobe cycle; otherwise hold.
  always_comb begin
    led_d = led_q;
    if (stb) begin
      led_d = i_led;
    end
  end

  // LED output register, cleared immediately by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led_d;
    end
  end

  assign o_led = led_q;
  assign o_stb = stb;

endmodule

// File: tb/tb_led_rate_limiter.sv
// Self-checking bench for led_rate_limiter with a cycle-count reference model.
module tb_led_rate_limiter;

   localparam int DivBits = 4;
   localparam int Period  = 1 << DivBits;

   logic clock = 1'b0;
   logic rst   = 1'b1;
   logic ledIn = 1'b0;
   logic ledOut, stbOut, clkOut;

   logic rstSweep = 1'b1;
   logic ledSweep = 1'b0;
   logic led2, stb2, clk2;
   logic led8, stb8, clk8;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: edges since reset release and expected outputs.
   int   edgeCount = 0;
   logic stbExp    = 1'b0;
   logic ledExp    = 1'b0;
   logic clkExp    = 1'b0;

   // Free-running 10-unit clock shared by every instance.
   always #5 clock = ~clock;

   led_rate_limiter #(.DIV_BITS(DivBits)) dut (
      .i_clk(clock), .i_rst(rst), .i_led(ledIn),
      .o_led(ledOut), .o_stb(stbOut), .o_clk(clkOut)
   );

   led_rate_limiter #(.DIV_BITS(2)) dut2 (
      .i_clk(clock), .i_rst(rstSweep), .i_led(ledSweep),
      .o_led(led2), .o_stb(stb2), .o_clk(clk2)
   );

   led_rate_limiter #(.DIV_BITS(8)) dut8 (
      .i_clk(clock), .i_rst(rstSweep), .i_led(ledSweep),
      .o_led(led8), .o_stb(stb8), .o_clk(clk8)
   );

   // One clock cycle: update the model at the rising edge, return at the falling edge.
   task automatic stepClock();
      @(posedge clock);
      if (rst) begin
         edgeCount = 0;
         stbExp    = 1'b0;
         ledExp    = 1'b0;
      end else begin
         if (stbExp) ledExp = ledIn;
         edgeCount++;
         stbExp = (edgeCount % Period == 0);
      end
      clkExp = ((edgeCount % Period) >= Period / 2);
      @(negedge clock);
   endtask

   // Pulse reset for one cycle and release it on a falling edge.
   task automatic doReset();
      rst = 1'b1;
      stepClock();
      rst = 1'b0;
   endtask

   // Outputs stay cleared while reset is held, then the divider phase starts at zero.
   task automatic test_reset();
      $display("[TB] test_reset");
      rst   = 1'b1;
      ledIn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stepClock();
         vectors++;
         if (ledOut !== 1'b0 || stbOut !== 1'b0 || clkOut !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold cyc=%0d led/stb/clk got %b%b%b want 000", i, ledOut, stbOut, clkOut);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 3 * Period + 2; i++) begin
         stepClock();
         vectors++;
         if (stbOut !== stbExp || clkOut !== clkExp) begin
            miscompares++;
            $display("[TB] FAIL divider edge=%0d stb/clk got %b%b want %b%b", edgeCount, stbOut, clkOut, stbExp, clkExp);
         end
      end
   endtask

   // Constant request: LED rises only one cycle after the first strobe.
   task automatic test_steady_request();
      $display("[TB] test_steady_request");
      ledIn = 1'b1;
      doReset();
      for (int i = 0; i < 2 * Period + 4; i++) begin
         stepClock();
         vectors++;
         if (ledOut !== ((edgeCount >= Period + 1) ? 1'b1 : 1'b0) || stbOut !== stbExp) begin
            miscompares++;
            $display("[TB] FAIL steady edge=%0d led/stb got %b%b want %b%b", edgeCount, ledOut, stbOut,
                     (edgeCount >= Period + 1), stbExp);
         end
      end
   endtask

   // Toggle every 14 cycles: output follows the strobe-cycle value, runs never shorter than a period.
   task automatic test_fast_toggle();
      logic prevLed;
      int   lastChange;
      bit   seenChange;
      $display("[TB] test_fast_toggle");
      ledIn = 1'b0;
      doReset();
      prevLed    = 1'b0;
      lastChange = 0;
      seenChange = 0;
      for (int i = 0; i < 400; i++) begin
         if (i > 0 && i % 14 == 0) ledIn = ~ledIn;
         stepClock();
         vectors++;
         if (ledOut !== ledExp || stbOut !== stbExp || clkOut !== clkExp) begin
            miscompares++;
            $display("[TB] FAIL toggle edge=%0d led/stb/clk got %b%b%b want %b%b%b", edgeCount,
                     ledOut, stbOut, clkOut, ledExp, stbExp, clkExp);
         end
         if (ledOut !== prevLed) begin
            if (seenChange && (edgeCount - lastChange) < Period) begin
               miscompares++;
               $display("[TB] FAIL toggle_run edge=%0d run got %0d want >=%0d", edgeCount, edgeCount - lastChange, Period);
            end
            seenChange = 1;
            lastChange = edgeCount;
            prevLed    = ledOut;
         end
      end
   endtask

   // A short pulse entirely between strobes never reaches the output.
   task automatic test_glitch();
      $display("[TB] test_glitch");
      ledIn = 1'b0;
      doReset();
      for (int i = 0; i < 3 * Period; i++) begin
         ledIn = (edgeCount >= Period + 4 && edgeCount < Period + 7) ? 1'b1 : 1'b0;
         stepClock();
         vectors++;
         if (ledOut !== 1'b0 || stbOut !== stbExp) begin
            miscompares++;
            $display("[TB] FAIL glitch edge=%0d led/stb got %b%b want 0%b", edgeCount, ledOut, stbOut, stbExp);
         end
      end
   endtask

   // Random request levels with random hold times against the model.
   task automatic test_random();
      int holdLeft = 0;
      $display("[TB] test_random");
      doReset();
      for (int i = 0; i < 300; i++) begin
         if (holdLeft == 0) begin
            ledIn    = 1'($urandom_range(0, 1));
            holdLeft = $urandom_range(1, 40);
         end
         holdLeft--;
         stepClock();
         vectors++;
         if (ledOut !== ledExp || stbOut !== stbExp || clkOut !== clkExp) begin
            miscompares++;
            $display("[TB] FAIL random edge=%0d led/stb/clk got %b%b%b want %b%b%b", edgeCount,
                     ledOut, stbOut, clkOut, ledExp, stbExp, clkExp);
         end
      end
   endtask

   // Reset between edges clears outputs at once; strobe phase restarts from zero.
   task automatic test_async_reset();
      $display("[TB] test_async_reset");
      ledIn = 1'b1;
      doReset();
      for (int i = 0; i < 2 * Period + 5; i++) stepClock();
      vectors++;
      if (ledOut !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL async_pre led got %b want 1", ledOut);
      end
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            doReset();
            while (edgeCount < Period) stepClock();
            vectors++;
            if (stbOut !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL async_stb_pre stb got %b want 1", stbOut);
            end
         end
         #2 rst = 1'b1;
         #1;
         vectors++;
         if (ledOut !== 1'b0 || stbOut !== 1'b0 || clkOut !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_clear pass=%0d led/stb/clk got %b%b%b want 000", pass, ledOut, stbOut, clkOut);
         end
         stepClock();
         rst = 1'b0;
         for (int i = 0; i < Period + 3; i++) begin
            stepClock();
            vectors++;
            if (ledOut !== ledExp || stbOut !== stbExp || clkOut !== clkExp) begin
               miscompares++;
               $display("[TB] FAIL async_after pass=%0d edge=%0d led/stb/clk got %b%b%b want %b%b%b", pass,
                        edgeCount, ledOut, stbOut, clkOut, ledExp, stbExp, clkExp);
            end
         end
      end
   endtask

   // Steady request on DIV_BITS=2 and DIV_BITS=8 instances: spacing 4 and 256.
   task automatic test_param_sweep();
      $display("[TB] test_param_sweep");
      @(negedge clock);
      rstSweep = 1'b1;
      ledSweep = 1'b1;
      @(negedge clock);
      rstSweep = 1'b0;
      for (int e = 1; e <= 600; e++) begin
         @(posedge clock);
         @(negedge clock);
         vectors++;
         if (stb2 !== (e % 4 == 0) || led2 !== (e >= 5) || clk2 !== ((e % 4) >= 2)) begin
            miscompares++;
            $display("[TB] FAIL sweep2 edge=%0d led/stb/clk got %b%b%b want %b%b%b", e, led2, stb2, clk2,
                     (e >= 5), (e % 4 == 0), ((e % 4) >= 2));
         end
         if (stb8 !== (e % 256 == 0) || led8 !== (e >= 257) || clk8 !== ((e % 256) >= 128)) begin
            miscompares++;
            $display("[TB] FAIL sweep8 edge=%0d led/stb/clk got %b%b%b want %b%b%b", e, led8, stb8, clk8,
                     (e >= 257), (e % 256 == 0), ((e % 256) >= 128));
         end
      end
   endtask

   // Run every scenario in order and report.
   initial begin
      test_reset();
      test_steady_request();
      test_fast_toggle();
      test_glitch();
      test_random();
      test_async_reset();
      test_param_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
